pipeline_mem_wb: RTL and testbench
==================================

Name: pipeline_mem_wb

Overview:
Producer end of the forwarding/writeback interface consumed by the ID stage. It accepts EX-stage results and performs data-memory loads and stores over a req/ack handshake, stalling EX while a request is outstanding. It drives the MEM-stage forwarding pair (reg_forward_mem/data_forward_mem) and the registered writeback pair (reg_write/data_write) into the register file. Register number 0 on any reg_* output means "no write".

Parameters:
DATA_W, 32, datapath and address width (matches COMMON_WIDTH).
REG_W, 5, register-number width (matches REG_NUM).

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
ex_valid  in  1  EX presents an instruction.
ex_ready  out  1  stage accepts the instruction this cycle.
ex_reg_dest  in  REG_W  destination register; 0 means none.
ex_result  in  DATA_W  ALU result, or effective address for mem ops.
ex_mem_op  in  4  0=NONE 1=LB 2=LH 3=LW 4=LBU 5=LHU 8=SB 9=SH 10=SW; all other codes are treated as NONE.
ex_store_data  in  DATA_W  store source value.
mem_req  out  1  memory request.
mem_we  out  1  1 = store.
mem_addr  out  DATA_W  word-aligned address {addr[31:2],2'b00}.
mem_be  out  4  byte enables.
mem_wdata  out  DATA_W  store data, lane-replicated.
mem_ack  in  1  request complete; mem_rdata valid in the same cycle.
mem_rdata  in  DATA_W  load word.
reg_forward_mem  out  REG_W  forwardable destination.
data_forward_mem  out  DATA_W  forward value.
reg_write  out  REG_W  writeback destination.
data_write  out  DATA_W  writeback data.
misalign_err  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset:
  - All outputs 0, except ex_ready=1.
  - State goes to IDLE and the M register is emptied.
- States:
  - IDLE: M register empty or holding a NONE op.
  - MEM_WAIT: a request is outstanding.
- Accept rule: the stage captures EX when ex_valid && ex_ready.
  - ex_ready = (state==IDLE) || (state==MEM_WAIT && mem_ack). This is a combinational path from mem_ack.
- NONE op (latency):
  - Held in M for one cycle.
  - Next edge it loads the WB register. reg_write/data_write become valid 2 cycles after acceptance.
- Legal mem op:
  - The capture edge enters MEM_WAIT.
  - mem_req=1 from the following cycle, with mem_addr/mem_be/mem_we/mem_wdata held stable until mem_ack.
  - On the mem_ack cycle: loads extract and extend data; stores write nothing.
  - The WB register is loaded on that edge.
  - mem_req drops the next cycle unless a new mem op was accepted in the same cycle. Back-to-back requests are allowed.
- Byte lanes (little-endian, a = addr[1:0]):
  - SB: be = 1<<a, wdata = {4{data[7:0]}}.
  - SH: be = 3<<a, wdata = {2{data[15:0]}}.
  - SW: be = 4'hF, wdata = data.
  - Loads use the same be.
  - LB/LBU: rdata byte a, sign- or zero-extended.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: full word.
- Misalignment (LH/LHU/SH with a[0]=1; LW/SW with a≠0):
  - No request is issued.
  - misalign_err pulses one cycle after capture.
  - The instruction retires with reg_write=0.
  - The stage stays in IDLE.
- Forwarding:
  - reg_forward_mem = M holds a NONE op ? M.dest : 0.
  - data_forward_mem = M.result.
  - Load data is never forwarded from M; it is forwarded only via the WB outputs.
- WB outputs:
  - Registered; valid for exactly one cycle per retired instruction, otherwise reg_write=0.
  - data_write holds its last value when reg_write=0.
  - Stores, misaligned accesses and dest=0 retire with reg_write=0.
- mem_ack outside MEM_WAIT is ignored.
- rst in MEM_WAIT: mem_req=0 from the next cycle. The pending op is dropped with no writeback, and a late ack is ignored.
- rst overrides accept: while rst=1 nothing is captured.

Test Plan:
- ALU op, dest=5, result=0x1234 at cycle 0 -> cycle 1: reg_forward_mem=5, data_forward_mem=0x1234; cycle 2: reg_write=5, data_write=0x1234; cycle 3: reg_write=0.
- LB dest=7, addr=0x103, mem_ack 3 cycles after mem_req, rdata=0x80FF0000 -> mem_addr=0x100, be=4'h8, ex_ready=0 while waiting, reg_forward_mem=0; writeback reg_write=7, data_write=0xFFFFFF80. Repeat with LBU -> data_write=0x00000080.
- SH addr=0x202, data=0x0000ABCD, ack next cycle -> mem_we=1, be=4'hC, wdata=0xABCDABCD; reg_write stays 0.
- LW dest=3, addr=0x6 -> no mem_req, misalign_err=1 for one cycle, reg_write=0.
- rst while mem_req=1, then mem_ack 2 cycles later -> mem_req=0 the cycle after rst, no writeback, ack ignored, ex_ready=1.
- Back-to-back ALU ops to regs 1, 2, 3, then one with dest=0 -> reg_write sequence 1, 2, 3, 0 on consecutive cycles with matching data; reg_forward_mem=0 for the dest=0 op.

Source files
------------

// File: rtl/pipeline_mem_wb.sv
// MEM/WB stage: turns EX results into data-memory requests and register writebacks,
// and presents the MEM-stage forwarding pair to ID.
module pipeline_mem_wb #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_W-1:0]  ex_reg_dest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [3:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [REG_W-1:0]  reg_forward_mem,
    output logic [DATA_W-1:0] data_forward_mem,
    output logic [REG_W-1:0]  reg_write,
    output logic [DATA_W-1:0] data_write,
    output logic              misalign_err
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_is_load = 1'b1;
            default:                             op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: op_is_store = 1'b1;
            default:             op_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: op_misaligned = a[0];
            OP_LW, OP_SW:         op_misaligned = (a != 2'b00);
            default:              op_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] op_be(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_be = 4'b0001 << a;
            OP_LH, OP_LHU, OP_SH: op_be = 4'b0011 << a;
            OP_LW, OP_SW:         op_be = 4'b1111;
            default:              op_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_lanes(input logic [3:0] op,
                                                      input logic [DATA_W-1:0] d);
        case (op)
            OP_SB:   store_lanes = {4{d[7:0]}};
            OP_SH:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    // Little-endian lane select followed by sign/zero extension.
    function automatic logic [DATA_W-1:0] load_extract(input logic [3:0] op,
                                                       input logic [1:0] a,
                                                       input logic [DATA_W-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   load_extract = {{(DATA_W-8){b[7]}}, b};
            OP_LBU:  load_extract = {{(DATA_W-8){1'b0}}, b};
            OP_LH:   load_extract = {{(DATA_W-16){h[15]}}, h};
            OP_LHU:  load_extract = {{(DATA_W-16){1'b0}}, h};
            default: load_extract = rd;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic                m_valid_q, m_valid_d;
    logic                m_none_q, m_none_d;
    logic                m_load_q, m_load_d;
    logic [3:0]          m_op_q, m_op_d;
    logic [REG_W-1:0]    m_dest_q, m_dest_d;
    logic [DATA_W-1:0]   m_result_q, m_result_d;
    logic [REG_W-1:0]    fwd_reg_q, fwd_reg_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [REG_W-1:0]    reg_write_q, reg_write_d;
    logic [DATA_W-1:0]   data_write_q, data_write_d;
    logic                misalign_q, misalign_d;

    logic ack_s, ready_s, accept_s;
    logic cap_load_s, cap_store_s, cap_mem_s, cap_mis_s, cap_issue_s;

    // Handshake and decode of the instruction presented by EX.
    always_comb begin
        ack_s       = (state_q == ST_MEM_WAIT) && mem_ack;
        ready_s     = (state_q == ST_IDLE) || ack_s;
        accept_s    = ex_valid && ready_s;
        cap_load_s  = op_is_load(ex_mem_op);
        cap_store_s = op_is_store(ex_mem_op);
        cap_mem_s   = cap_load_s || cap_store_s;
        cap_mis_s   = cap_mem_s && op_misaligned(ex_mem_op, ex_result[1:0]);
        cap_issue_s = accept_s && cap_mem_s && !cap_mis_s;
    end

    // Next-state for the FSM, the M register, the request and the WB register.
    always_comb begin
        state_d      = state_q;
        m_valid_d    = m_valid_q;
        m_none_d     = m_none_q;
        m_load_d     = m_load_q;
        m_op_d       = m_op_q;
        m_dest_d     = m_dest_q;
        m_result_d   = m_result_q;
        fwd_reg_d    = {REG_W{1'b0}};
        misalign_d   = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        reg_write_d  = {REG_W{1'b0}};
        data_write_d = data_write_q;

        if (cap_issue_s) begin
            state_d = ST_MEM_WAIT;
        end else if (ready_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end

        // M empties once its occupant retires unless a new instruction replaces it.
        if (accept_s) begin
            m_valid_d  = 1'b1;
            m_none_d   = !cap_mem_s;
            m_load_d   = cap_load_s;
            m_op_d     = ex_mem_op;
            m_dest_d   = ex_reg_dest;
            m_result_d = ex_result;
            fwd_reg_d  = cap_mem_s ? {REG_W{1'b0}} : ex_reg_dest;
            misalign_d = cap_mis_s;
        end else if (ready_s) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end

        if (cap_issue_s) begin
            mem_we_d    = cap_store_s;
            mem_addr_d  = {ex_result[DATA_W-1:2], 2'b00};
            mem_be_d    = op_be(ex_mem_op, ex_result[1:0]);
            mem_wdata_d = cap_store_s ? store_lanes(ex_mem_op, ex_store_data) : {DATA_W{1'b0}};
        end else begin
            mem_we_d    = mem_we_q;
            mem_addr_d  = mem_addr_q;
            mem_be_d    = mem_be_q;
            mem_wdata_d = mem_wdata_q;
        end

        if ((state_q == ST_IDLE) && m_valid_q && m_none_q && (m_dest_q != {REG_W{1'b0}})) begin
            reg_write_d  = m_dest_q;
            data_write_d = m_result_q;
        end else if (ack_s && m_load_q && (m_dest_q != {REG_W{1'b0}})) begin
            reg_write_d  = m_dest_q;
            data_write_d = load_extract(m_op_q, m_result_q[1:0], mem_rdata);
        end else begin
            reg_write_d  = {REG_W{1'b0}};
            data_write_d = data_write_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            m_valid_q    <= 1'b0;
            m_none_q     <= 1'b0;
            m_load_q     <= 1'b0;
            m_op_q       <= 4'd0;
            m_dest_q     <= {REG_W{1'b0}};
            m_result_q   <= {DATA_W{1'b0}};
            fwd_reg_q    <= {REG_W{1'b0}};
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {DATA_W{1'b0}};
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= {DATA_W{1'b0}};
            reg_write_q  <= {REG_W{1'b0}};
            data_write_q <= {DATA_W{1'b0}};
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_valid_q    <= m_valid_d;
            m_none_q     <= m_none_d;
            m_load_q     <= m_load_d;
            m_op_q       <= m_op_d;
            m_dest_q     <= m_dest_d;
            m_result_q   <= m_result_d;
            fwd_reg_q    <= fwd_reg_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            reg_write_q  <= reg_write_d;
            data_write_q <= data_write_d;
            misalign_q   <= misalign_d;
        end
    end

    assign ex_ready         = ready_s;
    assign mem_req          = (state_q == ST_MEM_WAIT);
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_be           = mem_be_q;
    assign mem_wdata        = mem_wdata_q;
    assign reg_forward_mem  = fwd_reg_q;
    assign data_forward_mem = m_result_q;
    assign reg_write        = reg_write_q;
    assign data_write       = data_write_q;
    assign misalign_err     = misalign_q;

endmodule

// File: tb/tb_pipeline_mem_wb.sv
// Directed bench for pipeline_mem_wb: a transaction-level reference model checked every
// cycle, plus hand-computed literal expectations from the test plan.
module tb_pipeline_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_reg_dest;
    logic [31:0] ex_result;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  reg_forward_mem;
    logic [31:0] data_forward_mem;
    logic [4:0]  reg_write;
    logic [31:0] data_write;
    logic        misalign_err;

    always #5 clk = ~clk;

    pipeline_mem_wb #(.DATA_W(32), .REG_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_reg_dest      (ex_reg_dest),
        .ex_result        (ex_result),
        .ex_mem_op        (ex_mem_op),
        .ex_store_data    (ex_store_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_be           (mem_be),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .reg_forward_mem  (reg_forward_mem),
        .data_forward_mem (data_forward_mem),
        .reg_write        (reg_write),
        .data_write       (data_write),
        .misalign_err     (misalign_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd8:  return 1;
            4'd2, 4'd5, 4'd9:  return 2;
            4'd3, 4'd10:       return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic bit op_signed(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd2);
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd10);
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input int a,
                                             input logic [31:0] rd);
        int          sz;
        logic [63:0] mask;
        logic [63:0] v;
        sz   = op_size(op);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = ({32'd0, rd} >> (8 * a)) & mask;
        if (op_signed(op) && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    bit          live = 1'b0;
    bit          busy;
    bit          e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    bit          p_load;
    logic [3:0]  p_op;
    logic [4:0]  p_dest;
    int          p_lane;
    bit          s_valid, s_alu;
    logic [4:0]  s_dest;
    logic [31:0] s_val;
    logic [4:0]  e_fwd_reg, e_wr_reg;
    logic [31:0] e_fwd_data, e_wr_data;
    bit          e_mis;

    task automatic model_step();
        logic [4:0] nwr;
        bit         acc;
        int         sz;
        int         a;
        if (rst) begin
            busy = 1'b0; s_valid = 1'b0; p_load = 1'b0; e_mis = 1'b0;
            e_fwd_reg = 5'd0; e_fwd_data = 32'd0; e_wr_reg = 5'd0; e_wr_data = 32'd0;
            e_we = 1'b0; e_addr = 32'd0; e_be = 4'd0; e_wdata = 32'd0;
            live = 1'b1;
        end else begin
            nwr = 5'd0;
            if (s_valid) begin
                if (s_alu && s_dest != 5'd0) begin nwr = s_dest; e_wr_data = s_val; end
            end else if (busy && mem_ack) begin
                if (p_load && p_dest != 5'd0) begin
                    nwr = p_dest;
                    e_wr_data = exp_load(p_op, p_lane, mem_rdata);
                end
            end
            acc = ex_valid && (!busy || mem_ack);
            if (busy && mem_ack) busy = 1'b0;
            s_valid = 1'b0; e_fwd_reg = 5'd0; e_mis = 1'b0;
            if (acc) begin
                sz = op_size(ex_mem_op);
                a  = int'(ex_result[1:0]);
                e_fwd_data = ex_result;
                if (sz == 0) begin
                    s_valid = 1'b1; s_alu = 1'b1; s_dest = ex_reg_dest; s_val = ex_result;
                    e_fwd_reg = ex_reg_dest;
                end else if ((a % sz) != 0) begin
                    s_valid = 1'b1; s_alu = 1'b0; e_mis = 1'b1;
                end else begin
                    busy   = 1'b1;
                    p_load = !op_store(ex_mem_op);
                    p_op   = ex_mem_op; p_dest = ex_reg_dest; p_lane = a;
                    e_we   = op_store(ex_mem_op);
                    e_addr = ex_result & ~32'h3;
                    e_be   = 4'(((1 << sz) - 1) << a);
                    if (sz == 1)      e_wdata = {24'd0, ex_store_data[7:0]} * 32'h01010101;
                    else if (sz == 2) e_wdata = {16'd0, ex_store_data[15:0]} * 32'h00010001;
                    else              e_wdata = ex_store_data;
                end
            end
            e_wr_reg = nwr;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle compare, half a cycle after the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                chk("ex_ready", 32'(ex_ready), 32'(!busy || mem_ack));
                chk("mem_req", 32'(mem_req), 32'(busy));
                if (busy) begin
                    chk("mem_we", 32'(mem_we), 32'(e_we));
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_be", 32'(mem_be), 32'(e_be));
                    if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
                end
                chk("reg_forward_mem", 32'(reg_forward_mem), 32'(e_fwd_reg));
                chk("data_forward_mem", data_forward_mem, e_fwd_data);
                chk("reg_write", 32'(reg_write), 32'(e_wr_reg));
                chk("data_write", data_write, e_wr_data);
                chk("misalign_err", 32'(misalign_err), 32'(e_mis));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] d, input logic [31:0] r,
                          input logic [3:0] op, input logic [31:0] sd);
        ex_valid = v; ex_reg_dest = d; ex_result = r; ex_mem_op = op; ex_store_data = sd;
    endtask

    task automatic set_mem(input logic ack, input logic [31:0] rd);
        mem_ack = ack; mem_rdata = rd;
    endtask

    initial begin
        logic [3:0]  lop;
        logic [31:0] lexp;
        rst = 1'b1;
        set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0);
        set_mem(1'b0, 32'd0);
        tick(); tick(); #2;
        chk("lit_rst_ready", 32'(ex_ready), 32'd1);
        chk("lit_rst_req", 32'(mem_req), 32'd0);
        chk("lit_rst_wr", 32'(reg_write), 32'd0);
        chk("lit_rst_mis", 32'(misalign_err), 32'd0);
        rst = 1'b0;

        // ALU op
        tick(); set_ex(1'b1, 5'd5, 32'h1234, 4'd0, 32'd0);
        tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); #2;
        chk("lit_alu_fwd", 32'(reg_forward_mem), 32'd5);
        chk("lit_alu_fdata", data_forward_mem, 32'h1234);
        tick(); #2;
        chk("lit_alu_wr", 32'(reg_write), 32'd5);
        chk("lit_alu_wdata", data_write, 32'h1234);
        tick(); #2;
        chk("lit_alu_wr_end", 32'(reg_write), 32'd0);

        // LB then LBU, ack three cycles after the request appears
        for (int k = 0; k < 2; k++) begin
            lop  = (k == 0) ? 4'd1 : 4'd4;
            lexp = (k == 0) ? 32'hFFFFFF80 : 32'h00000080;
            tick(); set_ex(1'b1, 5'd7, 32'h103, lop, 32'd0);
            tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); #2;
            chk("lit_ld_req", 32'(mem_req), 32'd1);
            chk("lit_ld_addr", mem_addr, 32'h100);
            chk("lit_ld_be", 32'(mem_be), 32'h8);
            chk("lit_ld_ready", 32'(ex_ready), 32'd0);
            chk("lit_ld_fwd", 32'(reg_forward_mem), 32'd0);
            tick(); tick();
            tick(); set_mem(1'b1, 32'h80FF0000); #2;
            chk("lit_ld_ready_ack", 32'(ex_ready), 32'd1);
            tick(); set_mem(1'b0, 32'd0); #2;
            chk("lit_ld_wr", 32'(reg_write), 32'd7);
            chk("lit_ld_wdata", data_write, lexp);
            chk("lit_ld_req_end", 32'(mem_req), 32'd0);
        end

        // SH, ack in the first request cycle
        tick(); set_ex(1'b1, 5'd9, 32'h202, 4'd9, 32'h0000ABCD);
        tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); set_mem(1'b1, 32'd0); #2;
        chk("lit_sh_we", 32'(mem_we), 32'd1);
        chk("lit_sh_be", 32'(mem_be), 32'hC);
        chk("lit_sh_wdata", mem_wdata, 32'hABCDABCD);
        tick(); set_mem(1'b0, 32'd0); #2;
        chk("lit_sh_wr", 32'(reg_write), 32'd0);
        chk("lit_sh_req_end", 32'(mem_req), 32'd0);

        // misaligned LW
        tick(); set_ex(1'b1, 5'd3, 32'h6, 4'd3, 32'd0);
        tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); #2;
        chk("lit_mis_req", 32'(mem_req), 32'd0);
        chk("lit_mis_pulse", 32'(misalign_err), 32'd1);
        tick(); #2;
        chk("lit_mis_end", 32'(misalign_err), 32'd0);
        chk("lit_mis_wr", 32'(reg_write), 32'd0);

        // reset while a request is outstanding, late ack afterwards
        tick(); set_ex(1'b1, 5'd4, 32'h40, 4'd3, 32'd0);
        tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); #2;
        chk("lit_rw_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick(); rst = 1'b0; #2;
        chk("lit_rw_req_off", 32'(mem_req), 32'd0);
        chk("lit_rw_ready", 32'(ex_ready), 32'd1);
        tick(); set_mem(1'b1, 32'h55);
        tick(); set_mem(1'b0, 32'd0); #2;
        chk("lit_rw_wr", 32'(reg_write), 32'd0);

        // back-to-back ALU ops to 1, 2, 3, then dest 0
        tick(); set_ex(1'b1, 5'd1, 32'h11, 4'd0, 32'd0);
        tick(); set_ex(1'b1, 5'd2, 32'h22, 4'd0, 32'd0); #2;
        chk("lit_b2b_fwd1", 32'(reg_forward_mem), 32'd1);
        tick(); set_ex(1'b1, 5'd3, 32'h33, 4'd0, 32'd0); #2;
        chk("lit_b2b_wr1", 32'(reg_write), 32'd1);
        chk("lit_b2b_wd1", data_write, 32'h11);
        tick(); set_ex(1'b1, 5'd0, 32'h44, 4'd0, 32'd0); #2;
        chk("lit_b2b_wr2", 32'(reg_write), 32'd2);
        chk("lit_b2b_wd2", data_write, 32'h22);
        tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); #2;
        chk("lit_b2b_wr3", 32'(reg_write), 32'd3);
        chk("lit_b2b_wd3", data_write, 32'h33);
        chk("lit_b2b_fwd0", 32'(reg_forward_mem), 32'd0);
        tick(); #2;
        chk("lit_b2b_wr0", 32'(reg_write), 32'd0);
        chk("lit_b2b_hold", data_write, 32'h33);

        // back-to-back requests: LW then LHU accepted on the LW ack cycle
        tick(); set_ex(1'b1, 5'd6, 32'h300, 4'd3, 32'd0);
        tick(); set_ex(1'b1, 5'd8, 32'h302, 4'd5, 32'd0); set_mem(1'b1, 32'hBEEF1234); #2;
        chk("lit_bb_ready", 32'(ex_ready), 32'd1);
        chk("lit_bb_be1", 32'(mem_be), 32'hF);
        tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); set_mem(1'b1, 32'h80010000); #2;
        chk("lit_bb_wr1", 32'(reg_write), 32'd6);
        chk("lit_bb_wd1", data_write, 32'hBEEF1234);
        chk("lit_bb_req2", 32'(mem_req), 32'd1);
        chk("lit_bb_be2", 32'(mem_be), 32'hC);
        tick(); set_mem(1'b0, 32'd0); #2;
        chk("lit_bb_wr2", 32'(reg_write), 32'd8);
        chk("lit_bb_wd2", data_write, 32'h00008001);

        // SB lane replication, then signed LH from the upper half
        tick(); set_ex(1'b1, 5'd0, 32'h401, 4'd8, 32'h0000005A);
        tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); set_mem(1'b1, 32'd0); #2;
        chk("lit_sb_be", 32'(mem_be), 32'h2);
        chk("lit_sb_wdata", mem_wdata, 32'h5A5A5A5A);
        tick(); set_ex(1'b1, 5'd10, 32'h12, 4'd2, 32'd0); set_mem(1'b0, 32'd0);
        tick(); set_ex(1'b0, 5'd0, 32'd0, 4'd0, 32'd0); set_mem(1'b1, 32'hFFFE0000); #2;
        chk("lit_lh_be", 32'(mem_be), 32'hC);
        tick(); set_mem(1'b0, 32'd0); #2;
        chk("lit_lh_wr", 32'(reg_write), 32'd10);
        chk("lit_lh_wdata", data_write, 32'hFFFFFFFE);

        // stray ack while idle
        tick(); set_mem(1'b1, 32'h12345678);
        tick(); set_mem(1'b0, 32'd0); #2;
        chk("lit_stray_wr", 32'(reg_write), 32'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
